hamming_decoder: RTL and testbench
==================================

Name: hamming_decoder

Overview:
- Receive-side counterpart of the transmit Hamming(12,8) encoder in the digital link.
- Accepts 12-bit codewords, computes a 4-bit syndrome, corrects any single-bit error and returns the 8-bit payload with error flags.
- Two-stage registered pipeline with valid/ready handshakes on both sides.
- Sits between the symbol/bit deframer and the byte sink.

Parameters:
- CNT_W, 16, width of the saturating error-statistics counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- din_valid  input  1  codeword valid
- din_ready  output  1  decoder can accept a codeword
- hc_in  input  12  codeword {d7,d6,d5,d4,p3,d3,d2,d1,p2,d0,p1,p0}
- dout_valid  output  1  decoded byte valid
- dout_ready  input  1  sink accepts byte
- data_out  output  8  decoded/corrected payload
- err_corr  output  1  single error detected and corrected (qualified by dout_valid)
- err_uncorr  output  1  syndrome 13..15, payload passed uncorrected
- syndrome  output  4  syndrome of the current output word
- clr_cnt  input  1  synchronous clear of statistics counters
- corr_cnt  output  CNT_W  corrected-word count
- uncorr_cnt  output  CNT_W  uncorrectable-word count

Behaviour:
- Reset: every output register clears to 0 (dout_valid, data_out, err_corr, err_uncorr, syndrome, corr_cnt, uncorr_cnt, internal stage-1 valid). din_ready follows combinationally and reads 1 while in reset.
- Bit position k (1..12) maps to hc_in[k-1]. Parity bits sit at positions 1, 2, 4, 8.
- Syndrome bit i = XOR of all hc_in bits whose position has bit i set:
  - s0 over positions 1,3,5,7,9,11
  - s1 over positions 2,3,6,7,10,11
  - s2 over positions 4,5,6,7,12
  - s3 over positions 8,9,10,11,12
- Stage 1: a transfer occurs when din_valid && din_ready. On transfer, register hc_in and the computed syndrome, and set s1_valid.
- Stage 2: correction and output register, decoded from the stage-1 syndrome:
  - syndrome 0: data is extracted as-is; err_corr=0, err_uncorr=0.
  - syndrome 1..12: invert bit position syndrome, then extract data; err_corr=1. A parity-bit position (1, 2, 4, 8) leaves data unchanged but err_corr is still 1.
  - syndrome 13..15: data extracted uncorrected; err_uncorr=1, err_corr=0.
- Limitation: a double error whose syndrome lands in 1..12 is miscorrected. This is inherent to the code and is not flagged.
- Flow control:
  - s2_ready = !dout_valid || dout_ready
  - s1_ready = !s1_valid || s2_ready
  - din_ready = s1_ready
- Latency: a codeword accepted in cycle N appears with dout_valid=1 at the start of cycle N+2 if there is no stall. Throughput is 1 word/cycle.
- Stalls:
  - dout_valid held with dout_ready=0: data_out, flags and syndrome stay stable.
  - The stage-1 word is held; no word is dropped or duplicated.
- Stage 2 empties (dout_valid cleared) when dout_ready=1 and stage 1 is empty.
- Counters:
  - A counter increments once per output handshake (dout_valid && dout_ready) carrying the relevant flag.
  - Counters saturate at 2^CNT_W-1.
  - clr_cnt has priority over an increment in the same cycle.
- Reset mid-operation: in-flight words are discarded; no output appears after reset release until new input arrives.

Optional Feature:
- HAMMING_DEC_STATS_EN defined: corr_cnt/uncorr_cnt counters are implemented as above.
- Not defined: counter logic is removed; corr_cnt and uncorr_cnt are tied to 0 and clr_cnt is ignored. Datapath and flags are unaffected.

Decomposition:
- Shared package hamming_pkg:
  - CW_W=12 and DATA_W=8
  - parity position constants
  - syndrome-class enum: CLEAN, CORR, UNCORR
  - data-extraction function (codeword to byte), shared with the encoder side
- One natural sub-module: hamming_syndrome. It is combinational, takes 12 bits in and gives 4 bits out, and is reusable by tests.

Test Plan:
- Byte 0xA5 encodes to hc=0xA27; send with dout_ready=1 -> after 2 cycles data_out=0xA5, syndrome=0, err_corr=0, err_uncorr=0.
- hc=0xA67 (bit 6, position 7, flipped) -> data_out=0xA5, syndrome=7, err_corr=1; corr_cnt increments to 1.
- hc=0xA26 (p0 flipped) -> data_out=0xA5, syndrome=1, err_corr=1.
- hc=0x226 (positions 12 and 1 flipped) -> syndrome=13, err_uncorr=1, data_out=0x25; uncorr_cnt=1.
- Back-to-back stream of 0xA27, 0xA67, 0x226 with dout_ready deasserted for 3 cycles mid-stream:
  - din_ready drops once both stages are full.
  - Outputs are held stable during the stall.
  - All three words emerge in order, with no loss or duplication.
- Assert rst_n low while both stages are full -> dout_valid=0 immediately and counters=0. With HAMMING_DEC_STATS_EN, pulse clr_cnt in the same cycle as an error handshake -> counter reads 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions used by both the encoder and decoder sides.
// Codeword layout (bit k-1 holds position k):
//   {d7,d6,d5,d4,p3,d3,d2,d1,p2,d0,p1,p0}
package hamming_pkg;

  localparam int CW_W   = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  // Positions (1-based) that carry parity rather than payload
  localparam logic [SYN_W-1:0] P0_POS = 4'd1;
  localparam logic [SYN_W-1:0] P1_POS = 4'd2;
  localparam logic [SYN_W-1:0] P2_POS = 4'd4;
  localparam logic [SYN_W-1:0] P3_POS = 4'd8;

  // Highest syndrome value that names a real bit position
  localparam logic [SYN_W-1:0] MAX_POS = 4'd12;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    CORR   = 2'd1,
    UNCORR = 2'd2
  } syn_class_e;

  // Pull the eight payload bits out of a codeword, skipping parity positions
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    return {cw[11:8], cw[6:4], cw[2]};
  endfunction

  // Zero means clean, 1..12 names a single flipped position, 13..15 cannot be located
  function automatic syn_class_e classify_syndrome(input logic [SYN_W-1:0] syn);
    if (syn == '0) begin
      return CLEAN;
    end else if (syn <= MAX_POS) begin
      return CORR;
    end else begin
      return UNCORR;
    end
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(12,8) syndrome generator.
// Syndrome bit i is the XOR of every codeword bit whose 1-based position has bit i set,
// so a single flipped bit yields its own position as the syndrome.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [SYN_W-1:0] syn
);

  // Fold each codeword bit into every syndrome bit selected by its position number
  always_comb begin
    syn = '0;
    for (int k = 1; k <= CW_W; k++) begin
      for (int i = 0; i < SYN_W; i++) begin
        if (k[i]) begin
          syn[i] = syn[i] ^ cw[k-1];
        end
      end
    end
  end

endmodule

// File: rtl/hamming_decoder.sv
// Hamming(12,8) receive decoder: two-stage valid/ready pipeline.
// Stage 1 registers the codeword and its syndrome; stage 2 corrects single errors,
// extracts the byte and presents it with error flags.
// Optional: define HAMMING_DEC_STATS_EN to build the saturating error counters;
// otherwise corr_cnt/uncorr_cnt read 0 and clr_cnt is ignored.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [CW_W-1:0]   hc_in,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [SYN_W-1:0]  syndrome,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              s1_valid;
  logic [CW_W-1:0]   s1_hc;
  logic [SYN_W-1:0]  s1_syn;
  logic [SYN_W-1:0]  syn_in;
  logic              s1_ready;
  logic              s2_ready;
  syn_class_e        s1_class;
  logic [CW_W-1:0]   corr_mask;
  logic [DATA_W-1:0] fixed_data;

  hamming_syndrome u_syndrome (
    .cw  (hc_in),
    .syn (syn_in)
  );

  // Each stage may load when it is empty or its contents are leaving this cycle
  assign s2_ready  = !dout_valid || dout_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign din_ready = s1_ready;

  // Stage 1: capture the incoming codeword together with its syndrome
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hc    <= '0;
      s1_syn   <= '0;
    end else if (s1_ready) begin
      s1_valid <= din_valid;
      if (din_valid) begin
        s1_hc  <= hc_in;
        s1_syn <= syn_in;
      end
    end
  end

  // Flip the named position for correctable syndromes, then strip parity bits
  always_comb begin
    s1_class  = classify_syndrome(s1_syn);
    corr_mask = '0;
    if (s1_class == CORR) begin
      corr_mask = CW_W'(1) << (s1_syn - 4'd1);
    end
    fixed_data = extract_data(s1_hc ^ corr_mask);
  end

  // Stage 2: output register, held while the sink stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      data_out   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      syndrome   <= '0;
    end else if (s2_ready) begin
      dout_valid <= s1_valid;
      if (s1_valid) begin
        data_out   <= fixed_data;
        err_corr   <= (s1_class == CORR);
        err_uncorr <= (s1_class == UNCORR);
        syndrome   <= s1_syn;
      end
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic out_fire;
  assign out_fire = dout_valid && dout_ready;

  // Saturating per-flag counters; a clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      if (err_corr && (corr_cnt != '1)) begin
        corr_cnt <= corr_cnt + 1'b1;
      end
      if (err_uncorr && (uncorr_cnt != '1)) begin
        uncorr_cnt <= uncorr_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard testbench for hamming_decoder: the driver pushes hand-computed
// expectations on each accepted codeword, the monitor pops on each output handshake.
module tb_hamming_decoder;

  localparam int CNT_W = 16;
`ifdef HAMMING_DEC_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] syn;
    logic       corr;
    logic       uncorr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             din_valid;
  logic             din_ready;
  logic [11:0]      hc_in;
  logic             dout_valid;
  logic             dout_ready;
  logic [7:0]       data_out;
  logic             err_corr;
  logic             err_uncorr;
  logic [3:0]       syndrome;
  logic             clr_cnt;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_corr = 0;
  int   exp_uncorr = 0;

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .hc_in      (hc_in),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .data_out   (data_out),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .syndrome   (syndrome),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point: every check goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(exp_corr));
    checkOutput({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'(exp_uncorr));
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the word
  task automatic applyStimulus(input logic [11:0] hc, input logic [7:0] data, input logic [3:0] syn,
                               input logic corr, input logic uncorr);
    exp_t e;
    int   wait_cycles;
    e = '{data: data, syn: syn, corr: corr, uncorr: uncorr};
    din_valid = 1'b1;
    hc_in = hc;
    wait_cycles = 0;
    forever begin
      @(negedge clk);
      if (din_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        break;
      end
      wait_cycles++;
      if (wait_cycles > 20) begin
        checkOutput("accept_timeout", 32'(din_ready), 32'd1);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Wait until every expected word has been seen, then let counters settle
  task automatic drain(input string tag);
    int wait_cycles;
    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 50) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() != 0) begin
      checkOutput({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on each output handshake, and check outputs hold during stalls
  exp_t       held;
  logic       held_ok = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_ok = 1'b0;
    end else begin
      if (dout_valid && !dout_ready) begin
        if (held_ok) begin
          checkOutput("stall_data", 32'(data_out), 32'(held.data));
          checkOutput("stall_syn", 32'(syndrome), 32'(held.syn));
          checkOutput("stall_flags", {30'd0, err_corr, err_uncorr}, {30'd0, held.corr, held.uncorr});
        end
        held = '{data: data_out, syn: syndrome, corr: err_corr, uncorr: err_uncorr};
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 32'(data_out), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          checkOutput("data_out", 32'(data_out), 32'(e.data));
          checkOutput("syndrome", 32'(syndrome), 32'(e.syn));
          checkOutput("err_corr", 32'(err_corr), 32'(e.corr));
          checkOutput("err_uncorr", 32'(err_uncorr), 32'(e.uncorr));
          if (STATS_EN) begin
            if (e.corr) exp_corr++;
            if (e.uncorr) exp_uncorr++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    din_valid = 1'b0;
    hc_in = '0;
    dout_ready = 1'b0;
    clr_cnt = 1'b0;
    #2;
    checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_din_ready", 32'(din_ready), 32'd1);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_syndrome", 32'(syndrome), 32'd0);
    checkOutput("rst_flags", {30'd0, err_corr, err_uncorr}, 32'd0);
    checkCounters("rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dout_ready = 1'b1;

    // Clean word, with latency check: valid two edges after acceptance
    applyStimulus(12'hA27, 8'hA5, 4'd0, 1'b0, 1'b0);
    din_valid = 1'b0;
    checkOutput("latency_n1", 32'(dout_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_n2", 32'(dout_valid), 32'd1);
    drain("clean");
    checkCounters("clean");

    // Data bit at position 7 flipped
    applyStimulus(12'hA67, 8'hA5, 4'd7, 1'b1, 1'b0);
    din_valid = 1'b0;
    drain("pos7");
    checkCounters("pos7");

    // Parity p0 flipped
    applyStimulus(12'hA26, 8'hA5, 4'd1, 1'b1, 1'b0);
    din_valid = 1'b0;
    drain("p0");

    // Double error at positions 12 and 1 -> syndrome 13, uncorrectable
    applyStimulus(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
    din_valid = 1'b0;
    drain("syn13");
    checkCounters("syn13");

    // Back-to-back burst at full rate: boundary syndromes 8, 12, 14, 15 and an all-zero word
    applyStimulus(12'hAA7, 8'hA5, 4'd8, 1'b1, 1'b0);
    applyStimulus(12'h227, 8'hA5, 4'd12, 1'b1, 1'b0);
    applyStimulus(12'h225, 8'h25, 4'd14, 1'b0, 1'b1);
    applyStimulus(12'h223, 8'h24, 4'd15, 1'b0, 1'b1);
    applyStimulus(12'h000, 8'h00, 4'd0, 1'b0, 1'b0);
    din_valid = 1'b0;
    drain("burst");
    checkCounters("burst");

    // Stream with a sink stall while both stages are full
    fork
      begin
        applyStimulus(12'hA27, 8'hA5, 4'd0, 1'b0, 1'b0);
        applyStimulus(12'hA67, 8'hA5, 4'd7, 1'b1, 1'b0);
        applyStimulus(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
        din_valid = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_din_ready", 32'(din_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        dout_ready = 1'b1;
      end
    join
    drain("stall");
    checkCounters("stall");

    // Fill both stages, then reset asynchronously mid-cycle
    dout_ready = 1'b0;
    applyStimulus(12'hA67, 8'hA5, 4'd7, 1'b1, 1'b0);
    applyStimulus(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
    din_valid = 1'b0;
    checkOutput("full_dout_valid", 32'(dout_valid), 32'd1);
    checkOutput("full_din_ready", 32'(din_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_corr = 0;
    exp_uncorr = 0;
    checkOutput("midrst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("midrst_din_ready", 32'(din_ready), 32'd1);
    checkCounters("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dout_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("postrst_dout_valid", 32'(dout_valid), 32'd0);

    // One corrected word to make the counter nonzero
    applyStimulus(12'hA67, 8'hA5, 4'd7, 1'b1, 1'b0);
    din_valid = 1'b0;
    drain("precl");
    checkCounters("precl");

    // Clear in the same cycle as a corrected-word handshake: clear wins
    applyStimulus(12'hA67, 8'hA5, 4'd7, 1'b1, 1'b0);
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
    checkOutput("clr_sb_empty", 32'(sb.size()), 32'd0);
    checkCounters("clr");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
